midi_note_decoder: RTL and testbench

//  Receives a serial MIDI byte stream (31250 baud, 8N1) and decodes Note On/Off into the

---
 rtl/midi_note_decoder.sv | 185 ++++++++++++++++++
 tb/tb_midi_note_decoder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_note_decoder.sv
// MIDI serial receiver and Note On/Off decoder driving a monophonic voice interface.
// Build option: define MIDI_CHANNEL_FILTER_EN to accept note messages only on CHANNEL.
module midi_note_decoder #(
   parameter int CLKS_PER_BIT = 3200,
   parameter int CHANNEL      = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       midi_rx,
   output logic [7:0] midi_data,
   output logic       midi_valid,
   output logic [7:0] amplitude,
   output logic       framing_err
);

   localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef MIDI_CHANNEL_FILTER_EN
   localparam bit CH_FILTER = 1'b1;
`else
   localparam bit CH_FILTER = 1'b0;
`endif

   typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
   typedef enum logic [1:0] {P_IDLE, P_IGNORE, P_WAIT_D1, P_WAIT_D2} parse_state_t;

   function automatic logic [7:0] scale_vel(input logic [6:0] vel);
      return {vel, vel[6]};
   endfunction

   logic             rx_s1, rx_s2;
   uart_state_t      ustate;
   logic             armed;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       rx_byte;
   logic             byte_vld_p0;

   parse_state_t     pstate;
   logic             note_on_st;
   logic [6:0]       note_d1;
   logic             exec_vld_p1;
   logic             exec_on_p1;
   logic [6:0]       exec_note_p1;
   logic [6:0]       exec_vel_p1;

   logic             is_rt;
   logic             ch_ok;
   logic             is_note_st;

   always_ff @(posedge clk) begin
      rx_s1 <= midi_rx;
      rx_s2 <= rx_s1;
   end

   // Stage p0: bit timing, start validation, stop check and byte strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         ustate      <= U_IDLE;
         armed       <= 1'b0;
         cnt         <= '0;
         bit_cnt     <= '0;
         byte_vld_p0 <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         byte_vld_p0 <= 1'b0;
         framing_err <= 1'b0;
         case (ustate)
            U_IDLE: begin
               cnt <= '0;
               if (!armed) begin
                  armed <= rx_s2;
               end else if (!rx_s2) begin
                  ustate <= U_START;
               end
            end
            U_START: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (rx_s2) begin
                     ustate <= U_IDLE;
                  end else begin
                     ustate  <= U_DATA;
                     bit_cnt <= '0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            U_DATA: begin
               if (cnt == FULL_M1) begin
                  cnt     <= '0;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) ustate <= U_STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            U_STOP: begin
               if (cnt == FULL_M1) begin
                  cnt    <= '0;
                  ustate <= U_IDLE;
                  // A low stop bit leaves the line low, so re-arm only once it returns high
                  if (rx_s2) begin
                     byte_vld_p0 <= 1'b1;
                     armed       <= 1'b1;
                  end else begin
                     framing_err <= 1'b1;
                     armed       <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: ustate <= U_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (ustate == U_DATA && cnt == FULL_M1) rx_byte <= {rx_s2, rx_byte[7:1]};
   end

   assign is_rt      = &rx_byte[7:3];
   assign ch_ok      = !CH_FILTER || (rx_byte[3:0] == 4'(CHANNEL));
   assign is_note_st = (rx_byte[7:5] == 3'b100) && ch_ok;

   // Stage p1: running-status message parser
   always_ff @(posedge clk) begin
      if (rst) begin
         pstate      <= P_IDLE;
         exec_vld_p1 <= 1'b0;
      end else begin
         exec_vld_p1 <= 1'b0;
         if (byte_vld_p0 && !is_rt) begin
            if (rx_byte[7]) begin
               pstate <= is_note_st ? P_WAIT_D1 : P_IGNORE;
            end else begin
               case (pstate)
                  P_WAIT_D1: pstate <= P_WAIT_D2;
                  P_WAIT_D2: begin
                     exec_vld_p1 <= 1'b1;
                     pstate      <= P_WAIT_D1;
                  end
                  default: pstate <= pstate;
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (byte_vld_p0 && !is_rt) begin
         if (rx_byte[7]) begin
            if (is_note_st) note_on_st <= rx_byte[4];
         end else if (pstate == P_WAIT_D1) begin
            note_d1 <= rx_byte[6:0];
         end else if (pstate == P_WAIT_D2) begin
            exec_note_p1 <= note_d1;
            exec_vel_p1  <= rx_byte[6:0];
            exec_on_p1   <= note_on_st && (rx_byte[6:0] != 7'd0);
         end
      end
   end

   // Stage p2: note execution into the voice interface registers
   always_ff @(posedge clk) begin
      if (rst) begin
         midi_data  <= '0;
         midi_valid <= 1'b0;
         amplitude  <= '0;
      end else if (exec_vld_p1) begin
         if (exec_on_p1) begin
            midi_data  <= {1'b0, exec_note_p1};
            amplitude  <= scale_vel(exec_vel_p1);
            midi_valid <= 1'b1;
         end else if (midi_valid && midi_data[6:0] == exec_note_p1) begin
            midi_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_midi_note_decoder.sv
// Bench for midi_note_decoder: directed vector table, timing corner cases and a
// randomized byte stream checked against a message-level reference model.
module tb_midi_note_decoder;

   localparam int B  = 16;
   localparam int CH = 0;

   logic       clk;
   logic       rst;
   logic       midi_rx;
   logic [7:0] midi_data;
   logic       midi_valid;
   logic [7:0] amplitude;
   logic       framing_err;

   int n_vec;
   int n_err;

   midi_note_decoder #(.CLKS_PER_BIT(B), .CHANNEL(CH)) dut (
      .clk        (clk),
      .rst        (rst),
      .midi_rx    (midi_rx),
      .midi_data  (midi_data),
      .midi_valid (midi_valid),
      .amplitude  (amplitude),
      .framing_err(framing_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: current status byte (or -1) plus collected data bytes
   int         m_status;
   int         m_d[$];
   logic       m_valid;
   logic [7:0] m_data;
   logic [7:0] m_amp;

   function automatic bit chan_ok(input logic [7:0] b);
`ifdef MIDI_CHANNEL_FILTER_EN
      return (b % 16) == CH;
`else
      return 1'b1;
`endif
   endfunction

   function automatic void model_reset();
      m_status = -1;
      m_d.delete();
      m_valid = 1'b0;
      m_data  = 8'd0;
      m_amp   = 8'd0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      int note;
      int vel;
      if (b >= 8'hF8) return;
      if (b >= 8'h80) begin
         m_d.delete();
         if ((b / 16 == 8 || b / 16 == 9) && chan_ok(b)) m_status = int'(b);
         else m_status = -1;
         return;
      end
      if (m_status < 0) return;
      m_d.push_back(int'(b));
      if (m_d.size() == 2) begin
         note = m_d[0];
         vel  = m_d[1];
         m_d.delete();
         if (m_status >= 8'h90 && vel > 0) begin
            m_valid = 1'b1;
            m_data  = 8'(note);
            m_amp   = 8'(vel * 2 + (vel >= 64 ? 1 : 0));
         end else if (m_valid && int'(m_data) == note) begin
            m_valid = 1'b0;
         end
      end
   endfunction

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         midi_rx = fr[i];
         repeat (B - 1) @(negedge clk);
      end
      if (stop) begin
         model_byte(b);
      end else begin
         @(negedge clk);
         midi_rx = 1'b1;
         repeat (B - 1) @(negedge clk);
      end
   endtask

   task automatic check_model(input string tag);
      check8({tag, "_valid"}, {7'd0, midi_valid}, {7'd0, m_valid});
      check8({tag, "_data"}, midi_data, m_data);
      check8({tag, "_amp"}, amplitude, m_amp);
   endtask

   typedef struct packed {
      logic [39:0] bytes;
      logic [2:0]  n;
      logic        v;
      logic [7:0]  d;
      logic [7:0]  a;
   } vec_t;

   vec_t tbl[15];

   initial begin
      int         k;
      int         hits;
      int         pos;
      logic [7:0] q[$];
      logic [7:0] ch, note, vel;

      n_vec   = 0;
      n_err   = 0;
      rst     = 1'b1;
      midi_rx = 1'b1;
      model_reset();

      tbl[0]  = '{40'h90487F0000, 3'd3, 1'b1, 8'h48, 8'hFF};
      tbl[1]  = '{40'h4A40000000, 3'd2, 1'b1, 8'h4A, 8'h81};
      tbl[2]  = '{40'h4A00000000, 3'd2, 1'b0, 8'h4A, 8'h81};
      tbl[3]  = '{40'h90487F0000, 3'd3, 1'b1, 8'h48, 8'hFF};
      tbl[4]  = '{40'h803C000000, 3'd3, 1'b1, 8'h48, 8'hFF};
      tbl[5]  = '{40'h8048400000, 3'd3, 1'b0, 8'h48, 8'hFF};
      tbl[6]  = '{40'h90F83CFE64, 3'd5, 1'b1, 8'h3C, 8'hC9};
      tbl[7]  = '{40'hB007400000, 3'd3, 1'b1, 8'h3C, 8'hC9};
      tbl[8]  = '{40'h3C7F000000, 3'd2, 1'b1, 8'h3C, 8'hC9};
`ifdef MIDI_CHANNEL_FILTER_EN
      tbl[9]  = '{40'h91407F0000, 3'd3, 1'b1, 8'h3C, 8'hC9};
      tbl[10] = '{40'h9F50000000, 3'd3, 1'b1, 8'h3C, 8'hC9};
`else
      tbl[9]  = '{40'h91407F0000, 3'd3, 1'b1, 8'h40, 8'hFF};
      tbl[10] = '{40'h9F50000000, 3'd3, 1'b1, 8'h40, 8'hFF};
`endif
      tbl[11] = '{40'h9040010000, 3'd3, 1'b1, 8'h40, 8'h02};
      tbl[12] = '{40'h80407F0000, 3'd3, 1'b0, 8'h40, 8'h02};
      tbl[13] = '{40'h9041C00500, 3'd4, 1'b0, 8'h40, 8'h02};
      tbl[14] = '{40'h904210E000, 3'd4, 1'b1, 8'h42, 8'h20};

      repeat (4) @(negedge clk);
      check8("rst_data", midi_data, 8'h00);
      check8("rst_valid", {7'd0, midi_valid}, 8'h00);
      check8("rst_amp", amplitude, 8'h00);
      check8("rst_ferr", {7'd0, framing_err}, 8'h00);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         for (int j = 0; j < int'(tbl[i].n); j++) send_byte(tbl[i].bytes[39-8*j -: 8], 1'b1);
         repeat (2 * B) @(negedge clk);
         check8($sformatf("tbl%0d_valid", i), {7'd0, midi_valid}, {7'd0, tbl[i].v});
         check8($sformatf("tbl%0d_data", i), midi_data, tbl[i].d);
         check8($sformatf("tbl%0d_amp", i), amplitude, tbl[i].a);
      end

      // Latency from start of final byte: 2 sync + 1 detect + half bit + 9 bits + 2
      send_byte(8'h80, 1'b1);
      send_byte(8'h42, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h90, 1'b1);
      send_byte(8'h45, 1'b1);
      k = 0;
      fork
         send_byte(8'h50, 1'b1);
         begin
            @(negedge clk);
            for (k = 1; k <= 400; k++) begin
               @(posedge clk);
               #1;
               if (midi_valid) break;
            end
         end
      join
      check_int("latency_cycles", k, 3 + B / 2 + 9 * B + 2);
      check_model("lat");

      // Low stop bit: one-cycle framing_err pulse, byte dropped
      hits = 0;
      pos  = 0;
      fork
         send_byte(8'h33, 1'b0);
         begin
            @(negedge clk);
            for (int c = 1; c <= 10 * B + 20; c++) begin
               @(posedge clk);
               #1;
               if (framing_err) begin
                  hits++;
                  pos = c;
               end
            end
         end
      join
      check_int("ferr_pulse_len", hits, 1);
      check_int("ferr_pulse_pos", pos, 3 + B / 2 + 9 * B);
      repeat (B) @(negedge clk);
      check_model("ferr");

      // False start: short glitch must not start a frame
      @(negedge clk);
      midi_rx = 1'b0;
      repeat (4) @(negedge clk);
      midi_rx = 1'b1;
      repeat (6) @(negedge clk);
      send_byte(8'h90, 1'b1);
      send_byte(8'h3E, 1'b1);
      send_byte(8'h22, 1'b1);
      repeat (2 * B) @(negedge clk);
      check_model("glitch");

      // Reset while the line is low mid-frame: receiver must wait for idle high
      send_byte(8'h90, 1'b1);
      fork
         send_byte(8'h00, 1'b1);
         begin
            repeat (3 * B) @(negedge clk);
            rst = 1'b1;
            model_reset();
            repeat (2) @(negedge clk);
            rst = 1'b0;
         end
      join
      check_model("midrst");
      send_byte(8'h90, 1'b1);
      send_byte(8'h45, 1'b1);
      send_byte(8'h60, 1'b1);
      repeat (2 * B) @(negedge clk);
      check8("midrst_note", midi_data, 8'h45);
      check8("midrst_amp", amplitude, 8'hC1);
      check_model("midrst2");

      // Randomized stream against the reference model
      for (int it = 0; it < 40; it++) begin
         ch   = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(0, 15));
         note = 8'($urandom_range(8'h30, 8'h33));
         vel  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
         q.delete();
         case ($urandom_range(0, 9))
            0, 1, 2: q = '{8'h90 | ch, note, vel};
            3, 4:    q = '{8'h80 | ch, note, vel};
            5:       q = '{note, vel};
            6:       q = '{8'h90 | ch, note, 8'(8'hF8 + $urandom_range(0, 7)), vel};
            7:       q = '{8'($urandom_range(8'hA0, 8'hF7)), note, vel};
            8:       send_byte(8'($urandom_range(0, 255)), 1'b0);
            default: q = '{8'h90 | ch, note, 8'h80 | ch, note, vel};
         endcase
         foreach (q[j]) send_byte(q[j], 1'b1);
         repeat (2 * B) @(negedge clk);
         check_model($sformatf("rnd%0d", it));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
